// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver. Oversamples the rx line, validates the start
//             bit at its midpoint, shifts in 8 data bits LSB first and checks
//             the stop bit. The received byte is offered through a
//             valid/ack handshake. Overrun and framing errors are flagged.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, all logic on posedge
//    rst_n       in   synchronous reset, active low
//    rx          in   asynchronous serial input, idle high
//    data        out  last received byte
//    data_valid  out  byte available, held until acknowledged
//    data_ack    in   consumer accepts byte (only honoured while data_valid=1)
//    busy        out  frame reception in progress
//    frame_err   out  one-clk pulse: stop bit sampled low
//    overrun     out  one-clk pulse: byte completed while previous one unread
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SAMPLE_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            rx_meta;
  logic            rx_s;
  logic            rx_prev;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   sample_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            tick;
  logic            fall_edge;
  logic            sample_en;
  logic            finish_ok;
  logic            finish_bad;

  assign tick      = (state != IDLE) && (tick_cnt == TICK_LAST);
  // Only a genuine 1->0 transition arms the receiver, so a held-low line
  // (break) cannot retrigger it.
  assign fall_edge = rx_prev && !rx_s;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    sample_en  = 1'b0;
    finish_ok  = 1'b0;
    finish_bad = 1'b0;
    case (state)
      IDLE: begin
        if (fall_edge) next_state = START;
      end
      START: begin
        // Mid start bit: a line back high means the edge was a glitch.
        if (tick && sample_cnt == SAMPLE_HALF) begin
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && sample_cnt == SAMPLE_LAST) begin
          sample_en = 1'b1;
          if (bit_cnt == 3'd7) next_state = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a following
        // start edge with no idle gap.
        if (tick && sample_cnt == SAMPLE_LAST) begin
          next_state = IDLE;
          finish_ok  = rx_s;
          finish_bad = !rx_s;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      tick_cnt   <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;

      if (state == IDLE || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      // Sample counter restarts on every state change and after each data bit.
      if (state == IDLE || next_state != state || sample_en) begin
        sample_cnt <= '0;
      end else if (tick) begin
        sample_cnt <= sample_cnt + 1'b1;
      end

      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (sample_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (sample_en) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
      end

      frame_err <= finish_bad;
      // An ack arriving in the completion cycle frees the slot, so no overrun.
      overrun   <= finish_ok && data_valid && !data_ack;

      if (finish_ok) begin
        data       <= shift_reg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Scoreboard testbench for uart_rx. The driver serialises frames
//             and pushes the expected outcome; an independent monitor pops
//             and compares whenever the receiver reports a byte or an error.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD_RATE  = 12_500;
  localparam int OVERSAMPLE = 16;
  localparam int TICK       = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT        = TICK * OVERSAMPLE;
  // Start edge to report: 2 sync flops + edge flop, then 9.5 bit periods.
  localparam int LAT_LO     = (BIT * 19) / 2;
  localparam int LAT_HI     = (BIT * 19) / 2 + 6;

  localparam int K_VALID = 0;
  localparam int K_OVR   = 1;
  localparam int K_FERR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .data_ack  (data_ack),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       valid;
    longint     start;
  } ev_t;

  ev_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: last good byte and whether it is still unread.
  logic [7:0] last_data = 8'h00;
  logic       pending   = 1'b0;
  logic       auto_ack  = 1'b1;
  int         ack_reqs  = 0;
  int         ack_done  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    if (!stop) begin
      e.kind  = K_FERR;
      e.data  = last_data;
      e.valid = pending;
    end else begin
      e.kind    = pending ? K_OVR : K_VALID;
      e.data    = b;
      e.valid   = 1'b1;
      last_data = b;
      pending   = !auto_ack;
    end
    e.start = cyc;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  // Consumer: acknowledges automatically or on request from the driver.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && data_valid && (auto_ack || ack_reqs != ack_done)) begin
        data_ack = 1'b1;
        if (ack_reqs != ack_done) ack_done++;
        @(negedge clk);
        data_ack = 1'b0;
        chk("ack_clears_valid", data_valid, 0);
      end
    end
  end

  // Monitor: pops an expectation for every reported byte or error.
  initial begin
    logic prev_v;
    ev_t  e;
    int   kind;
    longint lat;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (frame_err || overrun || (data_valid && !prev_v)) begin
          kind = frame_err ? K_FERR : (overrun ? K_OVR : K_VALID);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none (cycle %0d)",
                     kind, data, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_data", data, e.data);
            chk("event_valid", data_valid, e.valid);
            lat = cyc - e.start;
            n_total++;
            if (lat >= LAT_LO && lat <= LAT_HI) n_pass++;
            else $display("FAIL latency: got %0d clk, expected %0d..%0d", lat, LAT_LO, LAT_HI);
          end
        end
        prev_v = data_valid;
      end
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       bad;
    int         gap;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_data", data, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun, 0);
    idle_bits(1);

    // Single byte with ack
    send_frame(8'h55, 1'b1);
    idle_bits(2);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(2);

    // Short start glitch must be rejected
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_armed", busy, 1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_busy_cleared", busy, 0);
    idle_bits(2);

    // Stop bit forced low: frame error, data keeps 0xFF, valid stays low
    send_frame(8'h3C, 1'b0);
    idle_bits(2);

    // Overrun: two bytes with no ack
    auto_ack = 1'b0;
    send_frame(8'hA1, 1'b1);
    send_frame(8'h7E, 1'b1);
    idle_bits(1);
    chk("overrun_data_held", data, 8'h7E);
    chk("overrun_valid_held", data_valid, 1);

    // Reset in the middle of bit 4 of 0xC3 aborts the frame
    b  = 8'hC3;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx = b[i];
      repeat ((i == 4) ? BIT / 2 : BIT) @(negedge clk);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    rst_n     = 1'b1;
    pending   = 1'b0;
    last_data = 8'h00;
    chk("midreset_data", data, 0);
    chk("midreset_valid", data_valid, 0);
    chk("midreset_busy", busy, 0);
    idle_bits(2);
    chk("midreset_stays_idle", busy, 0);
    auto_ack = 1'b1;
    send_frame(8'h5A, 1'b1);
    idle_bits(2);

    // Randomised traffic, occasional bad stop bits and back-to-back frames
    for (int n = 0; n < 14; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad);
      gap = bad ? 1 : int'($urandom_range(0, 2));
      idle_bits(gap);
    end
    idle_bits(1);

    for (int w = 0; w < 4 * BIT && exp_q.size() != 0; w++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
